// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg: shared constants and state encoding for the data memory arbiter
package data_mem_arbiter_pkg;
    localparam int IO_SEL_BIT    = 15;
    localparam int MAX_WAIT_DEF  = 4;
    localparam int BURST_MAX_DEF = 8;
    typedef enum logic {IDLE = 1'b0, DMA_BURST = 1'b1} state_t;
endpackage

// File: rtl/data_mem_arbiter_mux.sv
// arb_port_mux: steers the granted port onto the shared memory/IO bus and decodes bit 15
module arb_port_mux
    import data_mem_arbiter_pkg::*;
(
    input  logic        cpu_gnt,
    input  logic        dma_gnt,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic        io_we,
    output logic        io_re
);
    logic any_gnt, we, is_io;
    assign mem_addr  = dma_gnt ? dma_addr : cpu_addr;
    assign mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
    assign we        = dma_gnt ? dma_we : cpu_we;
    assign any_gnt   = cpu_gnt | dma_gnt;
    assign is_io     = mem_addr[IO_SEL_BIT];
    assign mem_we    = any_gnt & we & ~is_io;
    assign mem_re    = any_gnt & ~we & ~is_io;
    assign io_we     = any_gnt & we & is_io;
    assign io_re     = any_gnt & ~we & is_io;
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: CPU-priority arbiter with DMA starvation guard and bounded burst lock
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT  = MAX_WAIT_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int CW        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic [15:0] cpu_rdata,
    output logic        cpu_rvalid,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    input  logic        dma_last,
    output logic        dma_gnt,
    output logic [15:0] dma_rdata,
    output logic        dma_rvalid,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [15:0] mem_rdata,
    output logic        io_we,
    output logic        io_re,
    input  logic [15:0] io_rdata
);
    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d, beat_q, beat_d;
    logic [15:0]   cpu_rdata_q, dma_rdata_q, rd_data;
    logic          cpu_rvalid_q, dma_rvalid_q;

    arb_port_mux u_mux (
        .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .io_we(io_we), .io_re(io_re)
    );

    assign rd_data = mem_addr[IO_SEL_BIT] ? io_rdata : mem_rdata;

    // beat_cnt counts beats already granted, so the IDLE grant is beat 1 of the burst
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!rst) begin
            if (state_q == IDLE) begin
                dma_gnt = dma_req && (wait_q == CW'(MAX_WAIT) || !cpu_req);
                cpu_gnt = cpu_req && !dma_gnt;
                if (dma_gnt && !dma_last && BURST_MAX > 1) begin
                    state_d = DMA_BURST;
                    beat_d  = CW'(1);
                end
            end else begin
                dma_gnt = dma_req;
                beat_d  = beat_q + CW'(1);
                if (!dma_req || dma_last || beat_d == CW'(BURST_MAX)) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end
            end
        end
        wait_d = dma_gnt ? '0 : (dma_req && wait_q != CW'(MAX_WAIT)) ? wait_q + CW'(1) : wait_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            beat_q       <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            beat_q       <= beat_d;
            cpu_rvalid_q <= cpu_gnt && !cpu_we;
            dma_rvalid_q <= dma_gnt && !dma_we;
            if (cpu_gnt && !cpu_we) cpu_rdata_q <= rd_data;
            if (dma_gnt && !dma_we) dma_rdata_q <= rd_data;
        end
    end

    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dma_rvalid = dma_rvalid_q;
endmodule
